if_stage: RTL

- Instruction-fetch stage directly upstream of the control unit. Holds the PC and fetches from instruction memory over a req/ready handshake.
- Keeps a one-entry IF/ID register whose op/func fields drive the control unit.
- Applies the control unit's pcsource redirect when the decode stage consumes an instruction.
- Sustains one instruction per cycle when memory is ready and decode is not stalled.

---
 rtl/if_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem req/ready handshake and one-entry IF/ID register.
// Optional MIPS branch delay slot is enabled with `define IF_DELAY_SLOT_EN.
module if_stage #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          stall,
  input  logic [1:0]    pcsource,
  input  logic [AW-1:0] bpc,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] jpc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   inst,
  output logic          inst_valid,
  output logic [AW-1:0] inst_pc,
  output logic [AW-1:0] pc4
);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]   inst_q, inst_d;
  logic          valid_q, valid_d;

  logic          consume, redirect, slot_free, fetch_done;
  logic [AW-1:0] target_raw, target;

`ifdef IF_DELAY_SLOT_EN
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_tgt_q, pend_tgt_d;
`endif

  assign consume    = valid_q & ~stall;
  assign redirect   = consume & (pcsource != 2'b00);
  assign slot_free  = ~valid_q | consume;
  assign imem_req   = slot_free & resetn;
  assign imem_addr  = pc_q;
  assign fetch_done = imem_req & imem_ready;

  always_comb begin
    case (pcsource)
      2'b01:   target_raw = bpc;
      2'b10:   target_raw = ra;
      default: target_raw = jpc;
    endcase
  end

  // Redirect targets are forced word-aligned so imem_addr[1:0] stays zero.
  assign target = {target_raw[AW-1:2], 2'b00};

  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
`ifdef IF_DELAY_SLOT_EN
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (pend_q) begin
      // Waiting for the delay-slot word; the branch target is applied once it lands.
      if (fetch_done) begin
        inst_d     = imem_rdata;
        inst_pc_d  = pc_q;
        valid_d    = 1'b1;
        pc_d       = pend_tgt_q;
        pend_d     = 1'b0;
      end
    end else if (redirect) begin
      if (fetch_done) begin
        inst_d    = imem_rdata;
        inst_pc_d = pc_q;
        valid_d   = 1'b1;
        pc_d      = target;
      end else begin
        pend_d     = 1'b1;
        pend_tgt_d = target;
        valid_d    = 1'b0;
      end
    end else if (fetch_done) begin
      inst_d    = imem_rdata;
      inst_pc_d = pc_q;
      valid_d   = 1'b1;
      pc_d      = pc_q + AW'(4);
    end else if (consume) begin
      valid_d = 1'b0;
    end
`else
    // A same-cycle fetch on redirect is the wrong-path word and is dropped.
    if (redirect) begin
      pc_d    = target;
      valid_d = 1'b0;
    end else if (fetch_done) begin
      inst_d    = imem_rdata;
      inst_pc_d = pc_q;
      valid_d   = 1'b1;
      pc_d      = pc_q + AW'(4);
    end else if (consume) begin
      valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  end

`ifdef IF_DELAY_SLOT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end
`endif

  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign inst_pc    = inst_pc_q;
  assign pc4        = inst_pc_q + AW'(4);

endmodule
